// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared vector addresses, vector FSM states and bus snapshot type
package cpu_bus_pkg;
  localparam logic [14:0] VEC_LO_ADDR = 15'h7FFC;
  localparam logic [14:0] VEC_HI_ADDR = 15'h7FFD;
  typedef enum logic [1:0] {IDLE = 2'b00, SAW_FC = 2'b01, FIRE = 2'b10} vec_state_e;
  typedef struct packed {
    logic        romsel;
    logic        rw;
    logic [14:0] addr;
    logic [7:0]  data;
  } snap_t;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: STAGES-deep flop synchroniser (clk, async rst, d in, q out)
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/cpu_bus_monitor.sv
// cpu_bus_monitor: syncs NES CPU bus to clk; emits write strobes, vector-fetch soft_reset and m2_active
module cpu_bus_monitor
  import cpu_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m2,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic        wr_strobe,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        soft_reset,
  output logic        m2_active
);
  localparam logic [15:0] IDLE_MAX = 16'(IDLE_CYCLES);
  logic m2_s, romsel_s, rw_s, rise, fall, cap, rd;
  logic m2_prev_q, m2_prev_d, wr_strobe_q, wr_strobe_d, active_q, active_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [15:0] cnt_q, cnt_d;
  vec_state_e state_q, state_d;
  snap_t snap, com;
  snap_t [SYNC_STAGES:0] pipe_q, pipe_d;
  bit_sync #(.STAGES(SYNC_STAGES)) u_m2     (.clk(clk), .rst(reset), .d(m2),        .q(m2_s));
  bit_sync #(.STAGES(SYNC_STAGES)) u_romsel (.clk(clk), .rst(reset), .d(romsel),    .q(romsel_s));
  bit_sync #(.STAGES(SYNC_STAGES)) u_rw     (.clk(clk), .rst(reset), .d(cpu_rw_in), .q(rw_s));
  always_comb begin
    snap        = {romsel_s, rw_s, cpu_addr_in, cpu_data_in};
    pipe_d      = {pipe_q[SYNC_STAGES-1:0], snap};
    com         = pipe_q[SYNC_STAGES];
    m2_prev_d   = m2_s;
    rise        = ~m2_prev_q & m2_s;
    fall        = m2_prev_q & ~m2_s;
    cap         = fall & active_q & ~com.romsel;
    rd          = cap & com.rw;
    wr_strobe_d = cap & ~com.rw;
    wr_addr_d   = wr_strobe_d ? com.addr : wr_addr_q;
    wr_data_d   = wr_strobe_d ? com.data : wr_data_q;
    state_d     = !active_q         ? IDLE :
                  state_q == FIRE   ? IDLE :
                  !fall             ? state_q :
                  !rd               ? IDLE :
                  com.addr == VEC_LO_ADDR ? SAW_FC :
                  (state_q == SAW_FC && com.addr == VEC_HI_ADDR) ? FIRE : IDLE;
    cnt_d       = (rise | fall) ? '0 : cnt_q == IDLE_MAX ? cnt_q : cnt_q + 16'd1;
    active_d    = rise | (active_q & (cnt_d != IDLE_MAX));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pipe_q      <= '0;
      m2_prev_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      active_q    <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      m2_prev_q   <= m2_prev_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
    end
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign soft_reset = state_q == FIRE;
  assign m2_active  = active_q;
endmodule

// File: tb/tb_cpu_bus_monitor.sv
// tb_cpu_bus_monitor: directed stimulus with event-level model and per-cycle compare
module tb_cpu_bus_monitor;
  localparam int S = 2, IDLE = 255;
  logic clk = 0, reset = 1, m2 = 0, romsel = 1, rw = 1;
  logic [14:0] addr = 0;
  logic [7:0] data = 0;
  logic wr_strobe, soft_reset, m2_active;
  logic [14:0] wr_addr;
  logic [7:0] wr_data;
  cpu_bus_monitor #(.SYNC_STAGES(S), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .reset(reset), .m2(m2), .romsel(romsel), .cpu_rw_in(rw),
    .cpu_addr_in(addr), .cpu_data_in(data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .soft_reset(soft_reset), .m2_active(m2_active)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          c;
    bit          fall;
    bit          romsel;
    bit          rw;
    logic [14:0] addr;
    logic [7:0]  data;
  } ev_t;
  ev_t evq[$];
  ev_t ev;
  int checks = 0, errors = 0, cyc = 0;
  int strobe_cnt = 0, sr_cnt = 0, last_strobe_cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int s0, r0;
  bit m_active = 0, m_fc = 0, e_strobe, e_sr;
  int m_last = 0;
  logic [14:0] m_addr = 0;
  logic [7:0] m_data = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
    end
  endtask
  // A raw M2 edge driven after posedge n is seen by the bus logic at posedge n+S+1.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    e_strobe = 0;
    e_sr = 0;
    if (reset) begin
      evq.delete();
      m_active = 0;
      m_fc = 0;
      m_addr = 0;
      m_data = 0;
      m_last = cyc;
    end else begin
      while (evq.size() > 0 && evq[0].c <= cyc) begin
        ev = evq.pop_front();
        if (ev.fall && m_active && !ev.romsel) begin
          if (!ev.rw) begin
            e_strobe = 1;
            m_addr = ev.addr;
            m_data = ev.data;
            m_fc = 0;
          end else begin
            e_sr = m_fc && ev.addr == 15'h7FFD;
            m_fc = ev.addr == 15'h7FFC;
          end
        end else if (ev.fall) m_fc = 0;
        if (!ev.fall) m_active = 1;
        m_last = ev.c;
      end
      if (cyc - m_last >= IDLE) begin
        m_active = 0;
        m_fc = 0;
      end
    end
    chk("wr_strobe", wr_strobe, e_strobe);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("soft_reset", soft_reset, e_sr);
    chk("m2_active", m2_active, m_active);
    if (wr_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end
    if (soft_reset) sr_cnt++;
  end
  task automatic set_m2(bit v, bit rs, bit w, logic [14:0] a, logic [7:0] d);
    m2 = v;
    evq.push_back('{cyc + S + 1, !v, rs, w, a, d});
  endtask
  task automatic bus_cycle(bit rs, bit w, logic [14:0] a, logic [7:0] d);
    @(negedge clk);
    romsel = rs; rw = w; addr = a; data = d;
    repeat (3) @(negedge clk);
    set_m2(1, rs, w, a, d);
    repeat (8) @(negedge clk);
    fall_cyc = cyc;
    set_m2(0, rs, w, a, d);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (1000) @(negedge clk);
    chk("idle_no_m2_active", m2_active, 0);
    chk("idle_wr_addr", wr_addr, 0);
    s0 = strobe_cnt;
    bus_cycle(0, 0, 15'h1234, 8'hA5);
    repeat (6) @(negedge clk);
    chk("wr_count", strobe_cnt - s0, 1);
    chk("wr_latency", last_strobe_cyc - fall_cyc, 3);
    chk("wr_addr_lit", wr_addr, 15'h1234);
    chk("wr_data_lit", wr_data, 8'hA5);
    bus_cycle(1, 0, 15'h6000, 8'h3C);
    bus_cycle(0, 1, 15'h0ABC, 8'h77);
    repeat (4) @(negedge clk);
    chk("no_wr_count", strobe_cnt - s0, 1);
    chk("held_addr", wr_addr, 15'h1234);
    chk("held_data", wr_data, 8'hA5);
    r0 = sr_cnt;
    bus_cycle(0, 1, 15'h7FFC, 8'h00);
    bus_cycle(0, 1, 15'h7FFD, 8'h80);
    repeat (4) @(negedge clk);
    chk("vec_fc_fd", sr_cnt - r0, 1);
    r0 = sr_cnt;
    bus_cycle(0, 1, 15'h7FFC, 8'h00);
    bus_cycle(0, 1, 15'h0000, 8'h00);
    bus_cycle(0, 1, 15'h7FFD, 8'h80);
    repeat (4) @(negedge clk);
    chk("vec_broken", sr_cnt - r0, 0);
    r0 = sr_cnt;
    bus_cycle(0, 1, 15'h7FFC, 8'h00);
    bus_cycle(0, 1, 15'h7FFC, 8'h00);
    bus_cycle(0, 1, 15'h7FFD, 8'h80);
    repeat (4) @(negedge clk);
    chk("vec_fc_fc_fd", sr_cnt - r0, 1);
    r0 = sr_cnt;
    s0 = strobe_cnt;
    bus_cycle(0, 1, 15'h7FFC, 8'h00);
    bus_cycle(0, 0, 15'h0100, 8'h42);
    bus_cycle(0, 1, 15'h7FFD, 8'h80);
    repeat (4) @(negedge clk);
    chk("vec_write_break", sr_cnt - r0, 0);
    chk("vec_write_strobe", strobe_cnt - s0, 1);
    s0 = strobe_cnt;
    @(negedge clk);
    romsel = 0; rw = 0; addr = 15'h2222; data = 8'h99;
    set_m2(1, 0, 0, 15'h2222, 8'h99);
    repeat (300) @(negedge clk);
    chk("stall_inactive", m2_active, 0);
    set_m2(0, 0, 0, 15'h2222, 8'h99);
    repeat (10) @(negedge clk);
    chk("idle_write_no_strobe", strobe_cnt - s0, 0);
    chk("idle_write_addr", wr_addr, 15'h0100);
    romsel = 0; rw = 1; addr = 15'h0000;
    rise_cyc = cyc;
    set_m2(1, 0, 1, 15'h0000, 8'h00);
    repeat (S + 1) @(negedge clk);
    chk("restart_active", m2_active, 1);
    repeat (5) @(negedge clk);
    set_m2(0, 0, 1, 15'h0000, 8'h00);
    repeat (8) @(negedge clk);
    r0 = sr_cnt;
    bus_cycle(0, 1, 15'h7FFC, 8'h00);
    @(negedge clk);
    romsel = 0; rw = 1; addr = 15'h7FFD;
    repeat (3) @(negedge clk);
    set_m2(1, 0, 1, 15'h7FFD, 8'h80);
    repeat (8) @(negedge clk);
    set_m2(0, 0, 1, 15'h7FFD, 8'h80);
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_soft_reset", soft_reset, 0);
    chk("rst_active", m2_active, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("rst_no_pulse", sr_cnt - r0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_bus_monitor.md
Name: cpu_bus_monitor

Overview:
- Oversampling front end that sits directly upstream of the multicart mapper register file.
- Synchronises the NES CPU bus (m2, romsel, cpu_rw_in, address, data) into the board clock domain and turns each cartridge-space CPU write into one clean, single-cycle strobe carrying the latched address and data.
- Detects the reset-vector fetch sequence and raises a soft_reset pulse, so the mapper can return to the menu bank.
- Flags loss of M2 so downstream logic can hold its state.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on m2/romsel/cpu_rw_in; legal range 2..3.
- IDLE_CYCLES, 255: clk cycles without any m2 edge before m2_active drops; legal range 16..65535.

Ports:
- clk  in  1  board oscillator, ≥ 16× M2 frequency; the only clock.
- reset  in  1  asynchronous, active-high.
- m2  in  1  raw CPU M2.
- romsel  in  1  raw /ROMSEL, active low.
- cpu_rw_in  in  1  raw R/W; 1 = read.
- cpu_addr_in  in  15  raw CPU A14..A0.
- cpu_data_in  in  8  raw CPU D7..D0.
- wr_strobe  out  1  one-clk pulse per cartridge write.
- wr_addr  out  15  address of the last write; held until the next write.
- wr_data  out  8  data of the last write; held until the next write.
- soft_reset  out  1  one-clk pulse after the vector fetch sequence.
- m2_active  out  1  high while M2 is toggling.

Behaviour:
- Reset (async, active-high) clears all state:
  - wr_strobe=0, wr_addr=0, wr_data=0, soft_reset=0, m2_active=0.
  - Synchronisers, history pipe, FSM and idle counter all clear.
  - Asserting reset mid-operation kills any pending strobe or pulse.
- Synchronisers: m2, romsel and cpu_rw_in each pass through SYNC_STAGES flops, giving m2_s, romsel_s, rw_s.
- m2_prev is the registered m2_s.
  - fall = m2_prev & ~m2_s.
  - rise = ~m2_prev & m2_s.
- Bus history pipe:
  - Every clk, a snapshot {romsel_s, rw_s, cpu_addr_in, cpu_data_in} is pushed into a shift pipe of depth SYNC_STAGES+1.
  - The oldest entry is the committed snapshot. It is aligned with the last M2-high sample before the true falling edge.
  - Multi-bit buses are never used directly; only committed values reach the outputs.
- Write capture:
  - Triggers on fall when the committed romsel=0 and rw=0.
  - Next clk: wr_strobe=1, and wr_addr/wr_data load from the committed snapshot.
  - Latency is SYNC_STAGES+1 clk from the raw M2 fall to the strobe.
  - Exactly one strobe per M2 cycle.
  - Back-to-back CPU writes (RMW dummy + real) give two strobes; the last value wins downstream.
- Vector FSM. States: IDLE, SAW_FC, FIRE.
  - Evaluated on every fall; committed romsel must be 0 and rw must be 1.
  - IDLE → SAW_FC when the committed address is 0x7FFC (CPU $FFFC).
  - SAW_FC → FIRE when the very next M2 cycle reads 0x7FFD.
  - SAW_FC → IDLE on any other cycle, including writes and non-cartridge accesses.
  - FIRE: soft_reset=1 for one clk, then IDLE.
  - A read of 0x7FFC while in SAW_FC stays in SAW_FC.
  - Soft-reset latency is 1 clk after the 0x7FFD fall, plus the pipe delay.
- Idle watchdog:
  - A 16-bit counter clears on any rise or fall and otherwise increments, saturating at IDLE_CYCLES.
  - m2_active=0 when the counter equals IDLE_CYCLES.
  - m2_active=1 on the first rise after reset or after idle.
  - While m2_active=0, write capture and the FSM are inhibited, and the FSM is forced to IDLE.
- Simultaneous events: wr_strobe and soft_reset cannot coincide, because the FSM requires reads; a write that would break the FSM sequence still strobes normally.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - VEC_LO_ADDR=15'h7FFC and VEC_HI_ADDR=15'h7FFD.
  - The vector-FSM state enum.
  - A snapshot struct typedef {romsel, rw, addr[14:0], data[7:0]}.
- One sub-module, bit_sync, is a parameterised SYNC_STAGES flop chain with async reset. It is instantiated three times.

Test Plan:
- Reset then idle, no M2 → all outputs 0; m2_active stays 0 after 1000 clk.
- M2 at clk/16; write romsel=0, rw=0, addr 0x1234, data 0xA5 → exactly one wr_strobe, SYNC_STAGES+1 clk after the raw fall; wr_addr=0x1234, wr_data=0xA5, held afterwards.
- Write with romsel=1 (addr 0x6000 region), then a read with romsel=0 → no wr_strobe; wr_addr/wr_data keep their previous values.
- Reads 0x7FFC then 0x7FFD on consecutive M2 cycles → one soft_reset pulse. Reads 0x7FFC, 0x0000, 0x7FFD → no pulse. Reads 0x7FFC, 0x7FFC, 0x7FFD → one pulse.
- M2 stopped for 300 clk → m2_active falls at count 255. A write presented while idle → no strobe. M2 restarts → m2_active=1 on the first rise.
- Assert reset between the 0x7FFD fall and the FIRE state → no soft_reset pulse; all outputs 0 within the same cycle.
